mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage MIPS core.
- Accepts the execute-stage bus and tracks the single data-SRAM transaction issued for each load/store.
- Waits for and buffers the data_sram response; extracts and extends load data (including lwl/lwr byte strobes).
- Forwards results to decode, reports exception/eret state back to execute, and drops stale responses after a flush.

Parameters:
- CANCEL_W, 2, width of the counter of flushed-but-outstanding responses still to discard (saturates at 2^CANCEL_W-1).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  exception/eret flush from WB; kills the stage content.
- ws_allowin  in  1  WB can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  ES has an instruction.
- es_to_ms_bus  in  105  {store_op, bd, exc, exc_type[7:0], eret_flush, cp0_wen, res_from_cp0, cp0_addr[7:0], res_from_mem, inst_load[6:0], ld_extd_op[4:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
- ms_to_ws_valid  out  1  instruction ready for WB.
- ms_to_ws_bus  out  95  {bd, exc, exc_type[7:0], eret_flush, cp0_wen, res_from_cp0, cp0_addr[7:0], gr_we, rf_wstrb[3:0], dest[4:0], final_result[31:0], pc[31:0]}.
- stall_ms_bus  out  10  {{5{ms_valid && gr_we}}, dest}.
- forward_ms_bus  out  33  {fwd_valid, final_result}.
- ms_exc_eret  out  2  {ms_valid && eret_flush, ms_valid && exc}; feeds the ES es_exc_eret_bus[3:2].
- data_sram_data_ok  in  1  response for the oldest outstanding request.
- data_sram_rdata  in  32  response data.

Behaviour:
- Reset (resetn=0, asynchronous): ms_valid=0, state=IDLE, cancel_cnt=0, rdata_buf=0, bus register=0. Consequently ms_allowin=1, ms_to_ws_valid=0, fwd_valid=0, ms_exc_eret=0.
- Accept: when es_to_ms_valid && ms_allowin, register the bus and set ms_valid=1. mem_op = res_from_mem | store_op.
  - Every accepted mem_op has exactly one request in flight, whether or not exc is set.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- State machine (per held instruction):
  - IDLE: no response pending. Entered on accept of a non-mem_op.
  - WAIT: mem_op accepted, no data_ok yet. Entered on accept of a mem_op when cancel_cnt==0.
  - HOLD: response captured in rdata_buf, waiting for WB.
- Transitions:
  - WAIT + data_ok (cancel_cnt==0): if ws_allowin, retire the same cycle using data_sram_rdata directly (next state follows the new accept, else IDLE); otherwise latch rdata_buf and go to HOLD.
  - HOLD + ws_allowin: retire using rdata_buf.
- ms_ready_go = (state==IDLE) || (state==HOLD) || (state==WAIT && data_ok && cancel_cnt==0).
- Flush: ms_valid<=0, state<=IDLE. If state==WAIT and no data_ok in that cycle, cancel_cnt increments.
  - A mem_op accepted while cancel_cnt>0 still enters WAIT.
  - Any data_ok while cancel_cnt>0 decrements cancel_cnt and is ignored.
  - flush with simultaneous es_to_ms_valid: the flush wins and nothing is accepted.
- Load extraction, via sub-module ld_select, addressed by alu_result[1:0]:
  - lb/lbu/lh/lhu/lw: select bytes, sign/zero-extend per ld_extd_op, rf_wstrb=4'hf.
  - lwl, addr a: data = rdata<<(8*(3-a)), rf_wstrb = 4'hf<<(3-a).
  - lwr, addr a: data = rdata>>(8*a), rf_wstrb = 4'hf>>a.
- final_result = res_from_mem ? extracted data : alu_result. Non-loads use rf_wstrb=4'hf.
- If exc is set, gr_we is forwarded to WB unchanged; WB suppresses the write. MS does not modify exception fields.
- fwd_valid = ms_valid && gr_we && !res_from_cp0 && (!res_from_mem || (ms_ready_go && rf_wstrb==4'hf)).
- Stores: the data_ok response only releases the stall; rdata is ignored.

Decomposition:
- Shared header (mycpu.h): ES_TO_MS_BUS_WD=105, MS_TO_WS_BUS_WD=95, STALL_BUS_WD=10, FORWARD_BUS_WD=33, and the inst_load bit indices (lb,lbu,lh,lhu,lw,lwl,lwr).
- State encodings are local parameters.
- One combinational sub-module: ld_select (inst_load, ld_extd_op, addr[1:0], rdata → data[31:0], wstrb[3:0]).

Test Plan:
- lw to addr 0x100, data_ok 3 cycles later with rdata 0x8899AABB, ws_allowin=1 → ms_to_ws_valid on the data_ok cycle; final_result=0x8899AABB, rf_wstrb=4'hf, fwd_valid=1.
- lb at addr[1:0]=2 with rdata 0x12F45678 → 0xFFFFFFF4; lbu → 0x000000F4; lhu at addr 2 → 0x000012F4.
- lwl addr 1 with rdata 0xAABBCCDD → final_result=0xCCDD0000, rf_wstrb=4'b1100; lwr addr 1 → 0x00AABBCC, rf_wstrb=4'b0111.
- data_ok while ws_allowin=0 for 4 cycles, rdata changes afterwards → state HOLD; the buffered value is retired unchanged; ms_allowin stays 0 until retire.
- Load in WAIT, then flush, then a new lw accepted; first data_ok (0xDEAD) is dropped with cancel_cnt 1→0; second data_ok (0xBEEF) retires → final_result=0xBEEF.
- resetn asserted low mid-WAIT (asynchronously, between clock edges) → ms_valid=0 and ms_allowin=1 immediately; after release an ALU op retires in 1 cycle with alu_result passed through.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type bit indices, state encoding and bus layouts for the MEM stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 105;
  localparam int MS_TO_WS_BUS_WD = 95;
  localparam int STALL_BUS_WD    = 10;
  localparam int FORWARD_BUS_WD  = 33;

  // inst_load bit positions; ld_extd_op reuses LB..LW as a one-hot extension select
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;
  localparam int LD_LWL = 5;
  localparam int LD_LWR = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ms_state_e;

  typedef struct packed {
    logic        store_op;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret_flush;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic [6:0]  inst_load;
    logic [4:0]  ld_extd_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret_flush;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        gr_we;
    logic [3:0]  rf_wstrb;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline handshake (ES->MS->WS) and data-SRAM response signals seen by the MEM stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       ws_allowin;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

endinterface

// File: rtl/mem_stage_ld_select.sv
// Combinational load-data extraction: byte/half select with extension, lwl/lwr shifts and strobes.
module mem_stage_ld_select
  import mem_stage_pkg::*;
(
  input  logic [6:0]  i_inst_load,
  input  logic [4:0]  i_ld_extd_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data,
  output logic [3:0]  o_wstrb
);

  logic [31:0] w_shr;
  logic [15:0] w_half;
  logic        w_plain;

  assign w_shr   = i_rdata >> {i_addr, 3'b000};
  assign w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_plain = |i_inst_load[LD_LW:LD_LB];

  always_comb begin
    o_data  = i_rdata;
    o_wstrb = 4'hf;
    // ~addr == 3-addr for a 2-bit address
    if (i_inst_load[LD_LWL]) begin
      o_data  = i_rdata << {~i_addr, 3'b000};
      o_wstrb = 4'hf << ~i_addr;
    end else if (i_inst_load[LD_LWR]) begin
      o_data  = w_shr;
      o_wstrb = 4'hf >> i_addr;
    end else if (w_plain) begin
      if (i_ld_extd_op[LD_LB])       o_data = {{24{w_shr[7]}}, w_shr[7:0]};
      else if (i_ld_extd_op[LD_LBU]) o_data = {24'h0, w_shr[7:0]};
      else if (i_ld_extd_op[LD_LH])  o_data = {{16{w_half[15]}}, w_half};
      else if (i_ld_extd_op[LD_LHU]) o_data = {16'h0, w_half};
      else if (i_ld_extd_op[LD_LW])  o_data = i_rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: tracks one data-SRAM transaction per load/store, buffers the response
// until WB accepts, and discards responses that belong to flushed instructions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_flush,
  mem_stage_if.slave                m_if,
  output logic [STALL_BUS_WD-1:0]   o_stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0] o_forward_ms_bus,
  output logic [1:0]                o_ms_exc_eret
);

  logic                r_ms_valid;
  es_to_ms_t           r_bus;
  ms_state_e           r_state, w_state_nxt;
  logic [CANCEL_W-1:0] r_cancel_cnt;
  logic [31:0]         r_rdata_buf;

  es_to_ms_t   w_es_bus;
  ms_to_ws_t   w_ws_bus;
  logic        w_resp_ok, w_ready_go, w_allowin, w_accept, w_mem_op_in;
  logic        w_cancel_inc, w_cancel_dec, w_fwd_valid;
  logic [31:0] w_rdata, w_ld_data, w_final;
  logic [3:0]  w_ld_wstrb, w_rf_wstrb;

  assign w_es_bus    = m_if.es_to_ms_bus;
  assign w_mem_op_in = w_es_bus.res_from_mem | w_es_bus.store_op;

  // a response only belongs to the held instruction once all cancelled ones have drained
  assign w_resp_ok   = m_if.data_sram_data_ok && (r_cancel_cnt == '0);
  assign w_ready_go  = (r_state == S_IDLE) || (r_state == S_HOLD) ||
                       ((r_state == S_WAIT) && w_resp_ok);
  assign w_allowin   = !r_ms_valid || (w_ready_go && m_if.ws_allowin);
  assign w_accept    = m_if.es_to_ms_valid && w_allowin && !i_flush;

  assign w_cancel_inc = i_flush && (r_state == S_WAIT) && !w_resp_ok;
  assign w_cancel_dec = m_if.data_sram_data_ok && (r_cancel_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else if (w_accept) begin
      w_state_nxt = w_mem_op_in ? S_WAIT : S_IDLE;
    end else begin
      case (r_state)
        S_WAIT:  if (w_resp_ok) w_state_nxt = m_if.ws_allowin ? S_IDLE : S_HOLD;
        S_HOLD:  if (m_if.ws_allowin) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_ms_valid   <= 1'b0;
      r_bus        <= '0;
      r_cancel_cnt <= '0;
      r_rdata_buf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_flush)        r_ms_valid <= 1'b0;
      else if (w_allowin) r_ms_valid <= m_if.es_to_ms_valid;
      if (w_accept) r_bus <= w_es_bus;
      if ((r_state == S_WAIT) && w_resp_ok && !m_if.ws_allowin) r_rdata_buf <= m_if.data_sram_rdata;
      // flush of a WAIT coinciding with a stale response nets to no change
      if (w_cancel_inc && !w_cancel_dec && (r_cancel_cnt != '1)) r_cancel_cnt <= r_cancel_cnt + 1'b1;
      else if (w_cancel_dec && !w_cancel_inc) r_cancel_cnt <= r_cancel_cnt - 1'b1;
    end
  end

  assign w_rdata = (r_state == S_HOLD) ? r_rdata_buf : m_if.data_sram_rdata;

  mem_stage_ld_select u_ld_select (
    .i_inst_load  (r_bus.inst_load),
    .i_ld_extd_op (r_bus.ld_extd_op),
    .i_addr       (r_bus.alu_result[1:0]),
    .i_rdata      (w_rdata),
    .o_data       (w_ld_data),
    .o_wstrb      (w_ld_wstrb)
  );

  assign w_final    = r_bus.res_from_mem ? w_ld_data : r_bus.alu_result;
  assign w_rf_wstrb = r_bus.res_from_mem ? w_ld_wstrb : 4'hf;

  assign w_ws_bus = '{
    bd:           r_bus.bd,
    exc:          r_bus.exc,
    exc_type:     r_bus.exc_type,
    eret_flush:   r_bus.eret_flush,
    cp0_wen:      r_bus.cp0_wen,
    res_from_cp0: r_bus.res_from_cp0,
    cp0_addr:     r_bus.cp0_addr,
    gr_we:        r_bus.gr_we,
    rf_wstrb:     w_rf_wstrb,
    dest:         r_bus.dest,
    final_result: w_final,
    pc:           r_bus.pc
  };

  assign w_fwd_valid = r_ms_valid && r_bus.gr_we && !r_bus.res_from_cp0 &&
                       (!r_bus.res_from_mem || (w_ready_go && (w_rf_wstrb == 4'hf)));

  assign m_if.ms_allowin     = w_allowin;
  assign m_if.ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign m_if.ms_to_ws_bus   = w_ws_bus;
  assign o_stall_ms_bus      = {{5{r_ms_valid && r_bus.gr_we}}, r_bus.dest};
  assign o_forward_ms_bus    = {w_fwd_valid, w_final};
  assign o_ms_exc_eret       = {r_ms_valid && r_bus.eret_flush, r_ms_valid && r_bus.exc};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected retirements queued at issue, popped at retire.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic [STALL_BUS_WD-1:0]   stall_bus;
  logic [FORWARD_BUS_WD-1:0] fwd_bus;
  logic [1:0]                exc_eret;

  mem_stage_if u_if ();

  mem_stage #(.CANCEL_W(2)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_flush          (flush),
    .m_if             (u_if.slave),
    .o_stall_ms_bus   (stall_bus),
    .o_forward_ms_bus (fwd_bus),
    .o_ms_exc_eret    (exc_eret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  wstrb;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  ms_to_ws_t ws;
  assign ws = u_if.ms_to_ws_bus;

  // kind 0..6 = lb,lbu,lh,lhu,lw,lwl,lwr; 7 = store; 8 = ALU op
  function automatic logic [ES_TO_MS_BUS_WD-1:0] mk(int kind, logic [31:0] addr, logic [31:0] pc);
    es_to_ms_t b;
    b = '0;
    b.gr_we      = (kind != 7);
    b.dest       = 5'(kind + 1);
    b.alu_result = addr;
    b.pc         = pc;
    if (kind < 7) begin
      b.res_from_mem    = 1'b1;
      b.inst_load[kind] = 1'b1;
      if (kind < 5) b.ld_extd_op[kind] = 1'b1;
    end
    if (kind == 7) b.store_op = 1'b1;
    return b;
  endfunction

  function automatic exp_t model(int kind, logic [31:0] addr, logic [31:0] d, logic [31:0] pc);
    exp_t e;
    logic [7:0]  by;
    logic [15:0] hw;
    case (addr[1:0])
      2'd0:    by = d[7:0];
      2'd1:    by = d[15:8];
      2'd2:    by = d[23:16];
      default: by = d[31:24];
    endcase
    hw = addr[1] ? d[31:16] : d[15:0];
    e.pc = pc; e.wstrb = 4'hf; e.res = addr;
    case (kind)
      0: e.res = {{24{by[7]}}, by};
      1: e.res = {24'h0, by};
      2: e.res = {{16{hw[15]}}, hw};
      3: e.res = {16'h0, hw};
      4: e.res = d;
      5: case (addr[1:0])
           2'd0:    begin e.res = {d[7:0], 24'h0};  e.wstrb = 4'b1000; end
           2'd1:    begin e.res = {d[15:0], 16'h0}; e.wstrb = 4'b1100; end
           2'd2:    begin e.res = {d[23:0], 8'h0};  e.wstrb = 4'b1110; end
           default: begin e.res = d;                e.wstrb = 4'b1111; end
         endcase
      6: case (addr[1:0])
           2'd0:    begin e.res = d;                 e.wstrb = 4'b1111; end
           2'd1:    begin e.res = {8'h0, d[31:8]};   e.wstrb = 4'b0111; end
           2'd2:    begin e.res = {16'h0, d[31:16]}; e.wstrb = 4'b0011; end
           default: begin e.res = {24'h0, d[31:24]}; e.wstrb = 4'b0001; end
         endcase
      default: e.res = addr;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [ES_TO_MS_BUS_WD-1:0] b);
    int cyc = 0;
    @(negedge clk);
    u_if.es_to_ms_valid = 1'b1;
    u_if.es_to_ms_bus   = b;
    #1;
    while (!u_if.ms_allowin && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    n_checks++;
    if (u_if.ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL issue_allowin: ms_allowin=%b after %0d cycles, required 1", u_if.ms_allowin, cyc);
    end
    @(negedge clk);
    u_if.es_to_ms_valid = 1'b0;
  endtask

  // Drives data_ok after 'delay' cycles and compares the retiring instruction against the queue head.
  task automatic respond_check(input string name, input logic [31:0] rdata, input int delay, input logic exp_fwd);
    exp_t e;
    repeat (delay) @(negedge clk);
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = rdata;
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid: ms_to_ws_valid=%b, required 1", name, u_if.ms_to_ws_valid);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL %s_sb: scoreboard empty at retire, required one entry", name);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (ws.final_result !== e.res) begin
        n_fail++; $display("FAIL %s_result: got %h, required %h", name, ws.final_result, e.res);
      end
      n_checks++;
      if (ws.rf_wstrb !== e.wstrb || ws.pc !== e.pc) begin
        n_fail++; $display("FAIL %s_wstrb_pc: got %b/%h, required %b/%h", name, ws.rf_wstrb, ws.pc, e.wstrb, e.pc);
      end
    end
    n_checks++;
    if (fwd_bus[32] !== exp_fwd) begin
      n_fail++; $display("FAIL %s_fwd: fwd_valid=%b, required %b", name, fwd_bus[32], exp_fwd);
    end
    @(negedge clk);
    u_if.data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b0 || u_if.ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL %s_drain: valid=%b allowin=%b, required 0/1", name, u_if.ms_to_ws_valid, u_if.ms_allowin);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (u_if.ms_allowin !== 1'b1 || u_if.ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: allowin=%b valid=%b, required 1/0", u_if.ms_allowin, u_if.ms_to_ws_valid);
    end
    n_checks++;
    if (fwd_bus !== 33'h0 || exc_eret !== 2'b00 || stall_bus !== 10'h0) begin
      n_fail++; $display("FAIL reset_outputs: fwd=%h exc_eret=%b stall=%h, required 0", fwd_bus, exc_eret, stall_bus);
    end
    n_checks++;
    if (dut.r_cancel_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_cancel: cancel_cnt=%0d, required 0", dut.r_cancel_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_lw();
    sb_q.push_back(model(4, 32'h100, 32'h8899AABB, 32'hBFC00000));
    issue(mk(4, 32'h100, 32'hBFC00000));
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b0 || stall_bus !== {5'h1f, 5'd5}) begin
      n_fail++; $display("FAIL lw_wait: valid=%b stall=%h, required 0/%h", u_if.ms_to_ws_valid, stall_bus, {5'h1f, 5'd5});
    end
    respond_check("lw", 32'h8899AABB, 2, 1'b1);
  endtask

  task automatic test_loads();
    int          kinds[10] = '{0, 1, 3, 2, 5, 6, 5, 6, 0, 4};
    logic [1:0]  addrs[10] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0};
    logic [31:0] datas[10] = '{32'h12F45678, 32'h12F45678, 32'h12F45678, 32'h00008001, 32'hAABBCCDD,
                               32'hAABBCCDD, 32'h01234567, 32'h01234567, 32'h00008000, 32'h5A5A0F0F};
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      e = model(kinds[i], {30'h40, addrs[i]}, datas[i], 32'h2000 + 32'(4 * i));
      sb_q.push_back(e);
      issue(mk(kinds[i], {30'h40, addrs[i]}, 32'h2000 + 32'(4 * i)));
      respond_check($sformatf("load%0d", i), datas[i], i % 3, e.wstrb == 4'hf);
    end
  endtask

  task automatic test_hold();
    sb_q.push_back(model(4, 32'h200, 32'h11223344, 32'h3000));
    issue(mk(4, 32'h200, 32'h3000));
    u_if.ws_allowin        = 1'b0;
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'h11223344;
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b1 || u_if.ms_allowin !== 1'b0) begin
      n_fail++; $display("FAIL hold_first: valid=%b allowin=%b, required 1/0", u_if.ms_to_ws_valid, u_if.ms_allowin);
    end
    @(negedge clk);
    u_if.data_sram_data_ok = 1'b0;
    u_if.data_sram_rdata   = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (dut.r_state !== S_HOLD) begin
      n_fail++; $display("FAIL hold_state: state=%0d, required %0d", dut.r_state, S_HOLD);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (u_if.ms_allowin !== 1'b0 || ws.final_result !== 32'h11223344) begin
        n_fail++; $display("FAIL hold_cycle%0d: allowin=%b result=%h, required 0/11223344", c, u_if.ms_allowin, ws.final_result);
      end
      @(negedge clk); #1;
    end
    u_if.ws_allowin = 1'b1;
    respond_check("hold_retire", 32'hFFFFFFFF, 0, 1'b1);
  endtask

  task automatic test_flush();
    issue(mk(4, 32'h300, 32'h4000));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (dut.r_cancel_cnt !== 2'd1 || u_if.ms_to_ws_valid !== 1'b0 || u_if.ms_allowin !== 1'b1) begin
      n_fail++; $display("FAIL flush_cancel: cnt=%0d valid=%b allowin=%b, required 1/0/1", dut.r_cancel_cnt, u_if.ms_to_ws_valid, u_if.ms_allowin);
    end
    sb_q.push_back(model(4, 32'h304, 32'h0000BEEF, 32'h4004));
    issue(mk(4, 32'h304, 32'h4004));
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'h0000DEAD;
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_stale: valid=%b on stale response, required 0", u_if.ms_to_ws_valid);
    end
    @(negedge clk);
    u_if.data_sram_data_ok = 1'b0;
    #1;
    n_checks++;
    if (dut.r_cancel_cnt !== 2'd0 || u_if.ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: cnt=%0d valid=%b, required 0/0", dut.r_cancel_cnt, u_if.ms_to_ws_valid);
    end
    respond_check("flush_beef", 32'h0000BEEF, 1, 1'b1);
    @(negedge clk);
    u_if.es_to_ms_valid = 1'b1;
    u_if.es_to_ms_bus   = mk(8, 32'h55, 32'h4008);
    flush = 1'b1;
    @(negedge clk);
    u_if.es_to_ms_valid = 1'b0;
    flush = 1'b0;
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_wins: valid=%b after flush with es valid, required 0", u_if.ms_to_ws_valid);
    end
  endtask

  task automatic test_store();
    sb_q.push_back(model(7, 32'h500, 32'h0, 32'h5000));
    issue(mk(7, 32'h500, 32'h5000));
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b0 || fwd_bus[32] !== 1'b0) begin
      n_fail++; $display("FAIL store_wait: valid=%b fwd=%b, required 0/0", u_if.ms_to_ws_valid, fwd_bus[32]);
    end
    respond_check("store", 32'hA5A5A5A5, 1, 1'b0);
  endtask

  task automatic test_exc_eret();
    es_to_ms_t b;
    b = mk(8, 32'h10, 32'h6000);
    b.exc = 1'b1; b.exc_type = 8'h0C;
    issue(b);
    #1;
    n_checks++;
    if (exc_eret !== 2'b01 || ws.exc !== 1'b1 || ws.gr_we !== 1'b1 || ws.exc_type !== 8'h0C) begin
      n_fail++; $display("FAIL exc: exc_eret=%b exc=%b gr_we=%b type=%h, required 01/1/1/0c", exc_eret, ws.exc, ws.gr_we, ws.exc_type);
    end
    b.exc = 1'b0; b.eret_flush = 1'b1;
    issue(b);
    #1;
    n_checks++;
    if (exc_eret !== 2'b10) begin
      n_fail++; $display("FAIL eret: exc_eret=%b, required 10", exc_eret);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(mk(4, 32'h400, 32'h7000));
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (u_if.ms_allowin !== 1'b1 || u_if.ms_to_ws_valid !== 1'b0 || stall_bus !== 10'h0) begin
      n_fail++; $display("FAIL reset_mid: allowin=%b valid=%b stall=%h, required 1/0/0", u_if.ms_allowin, u_if.ms_to_ws_valid, stall_bus);
    end
    @(negedge clk);
    resetn = 1'b1;
    e = model(8, 32'hCAFEF00D, 32'h0, 32'h7004);
    issue(mk(8, 32'hCAFEF00D, 32'h7004));
    #1;
    n_checks++;
    if (u_if.ms_to_ws_valid !== 1'b1 || ws.final_result !== e.res || ws.rf_wstrb !== e.wstrb) begin
      n_fail++; $display("FAIL alu_after_reset: valid=%b result=%h wstrb=%b, required 1/%h/%b", u_if.ms_to_ws_valid, ws.final_result, ws.rf_wstrb, e.res, e.wstrb);
    end
    n_checks++;
    if (fwd_bus !== {1'b1, e.res}) begin
      n_fail++; $display("FAIL alu_fwd: fwd=%h, required %h", fwd_bus, {1'b1, e.res});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.es_to_ms_valid = 1'b1;
      u_if.es_to_ms_bus   = mk(8, 32'h1000 + 32'(i * 3), 32'h8000 + 32'(4 * i));
      sb_q.push_back(model(8, 32'h1000 + 32'(i * 3), 32'h0, 32'h8000 + 32'(4 * i)));
      @(negedge clk); #1;
      n_checks++;
      if (u_if.ms_to_ws_valid !== 1'b1 || sb_q.size() == 0) begin
        n_fail++; $display("FAIL b2b%0d_valid: valid=%b queue=%0d, required 1/nonzero", i, u_if.ms_to_ws_valid, sb_q.size());
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (ws.final_result !== e.res || ws.pc !== e.pc) begin
          n_fail++; $display("FAIL b2b%0d_data: got %h/%h, required %h/%h", i, ws.final_result, ws.pc, e.res, e.pc);
        end
      end
    end
    u_if.es_to_ms_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.es_to_ms_valid    = 1'b0;
    u_if.es_to_ms_bus      = '0;
    u_if.ws_allowin        = 1'b1;
    u_if.data_sram_data_ok = 1'b0;
    u_if.data_sram_rdata   = 32'h0;
    test_reset();
    test_lw();
    test_loads();
    test_hold();
    test_flush();
    test_store();
    test_exc_eret();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
